// File: rtl/latency_credit_buffer.sv
// Credit-gated output FIFO that sits behind a fixed-latency delay line.
// Ports: CLK, RESET_N, ISSUE/ISSUE_READY, DIN/DIN_VALID, DOUT/DOUT_VALID/DOUT_READY, COUNT, ERR, STALL_CYCLES.
// Optional macro LATENCY_CREDIT_BUFFER_STATS_EN enables the STALL_CYCLES counter.
module latency_credit_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY      = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ISSUE,
  output logic                  ISSUE_READY,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  DIN_VALID,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic [CNT_W-1:0]      COUNT,
  output logic                  ERR,
  output logic [15:0]           STALL_CYCLES
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  if (DELAY < 1) begin : g_bad_delay
    $error("latency_credit_buffer: DELAY must be >= 1");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("latency_credit_buffer: FIFO_DEPTH must be >= 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_inflight;
  logic                  r_err;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_ret;
  logic                  w_err_now;
  logic [CNT_W:0]        w_used;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_pop   = !w_empty && DOUT_READY;
  // A full FIFO can still take data when the head leaves this cycle.
  assign w_push  = DIN_VALID && (!w_full || w_pop);

  // Credits count stored plus in-flight items; only registered state.
  assign w_used      = {1'b0, r_count} + {1'b0, r_inflight};
  assign ISSUE_READY = (w_used < {1'b0, DEPTH_C});

  assign w_issue = ISSUE && ISSUE_READY;
  assign w_ret   = DIN_VALID && (r_inflight != '0);

  assign w_err_now = (ISSUE && !ISSUE_READY)
                   | (DIN_VALID && (r_inflight == '0))
                   | (DIN_VALID && w_full && !w_pop);

  assign DOUT_VALID = !w_empty;
  assign DOUT       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign COUNT      = r_count;
  assign ERR        = r_err;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= DIN;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_ret);
      if (w_err_now) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef LATENCY_CREDIT_BUFFER_STATS_EN
  logic [15:0] r_stall;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall <= '0;
    end else if (!w_empty && !DOUT_READY && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign STALL_CYCLES = r_stall;
`else
  assign STALL_CYCLES = '0;
`endif

endmodule

// File: tb/tb_latency_credit_buffer.sv
// Self-checking bench for latency_credit_buffer (DELAY=1, FIFO_DEPTH=4).
// Models the delay line and the FIFO as a queue and compares every cycle.
module tb_latency_credit_buffer;

  logic       CLK;
  logic       RESET_N;
  logic       ISSUE;
  logic       ISSUE_READY;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic [7:0] DOUT;
  logic       DOUT_VALID;
  logic       DOUT_READY;
  logic [2:0] COUNT;
  logic       ERR;
  logic [15:0] STALL_CYCLES;

  latency_credit_buffer dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .ISSUE        (ISSUE),
    .ISSUE_READY  (ISSUE_READY),
    .DIN          (DIN),
    .DIN_VALID    (DIN_VALID),
    .DOUT         (DOUT),
    .DOUT_VALID   (DOUT_VALID),
    .DOUT_READY   (DOUT_READY),
    .COUNT        (COUNT),
    .ERR          (ERR),
    .STALL_CYCLES (STALL_CYCLES)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

`ifdef LATENCY_CREDIT_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int DEPTH = 4;

  int       n_vec;
  int       n_err;
  bit [7:0] m_q[$];
  int       m_infl;
  bit       m_err;
  int       m_stall;
  bit       pv;
  bit [7:0] pd;
  bit [7:0] nd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    bit rd;
    rd = (m_q.size() + m_infl) < DEPTH;
    chk("count", 32'(COUNT), m_q.size());
    chk("dout_valid", 32'(DOUT_VALID), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("dout", 32'(DOUT), 32'(m_q[0]));
    chk("issue_ready", 32'(ISSUE_READY), 32'(rd));
    chk("err", 32'(ERR), 32'(m_err));
    chk("stall", 32'(STALL_CYCLES), STATS ? m_stall : 0);
  endtask

  // One clock: want=try to issue, legal=only issue when credit exists,
  // rdy=consumer ready, xdv=inject a DIN_VALID with no matching issue.
  task automatic tick(input bit want, input bit legal, input bit rdy,
                      input bit xdv);
    bit rd, iss, dv, iok, pop, full;
    bit [7:0] d;
    rd  = (m_q.size() + m_infl) < DEPTH;
    iss = want && (rd || !legal);
    dv  = pv || xdv;
    d   = pv ? pd : 8'($urandom);
    ISSUE      = iss;
    DIN        = d;
    DIN_VALID  = dv;
    DOUT_READY = rdy;
    #1;
    check_outs();
    iok  = iss && rd;
    pop  = (m_q.size() > 0) && rdy;
    full = (m_q.size() == DEPTH);
    if ((iss && !rd) || (dv && m_infl == 0) || (dv && full && !pop))
      m_err = 1'b1;
    if (m_q.size() > 0 && !rdy && m_stall < 65535) m_stall++;
    if (pop) void'(m_q.pop_front());
    if (dv && (!full || pop)) m_q.push_back(d);
    m_infl = m_infl + int'(iok) - int'(dv && m_infl > 0);
    pv = iok;
    if (iok) begin
      pd = nd;
      nd = nd + 8'd1;
    end
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; keep_pipe leaves the
  // item already in the delay line so it arrives after reset.
  task automatic do_reset(input bit keep_pipe);
    ISSUE     = 1'b0;
    DIN_VALID = 1'b0;
    RESET_N   = 1'b0;
    #1;
    m_q.delete();
    m_infl  = 0;
    m_err   = 1'b0;
    m_stall = 0;
    if (!keep_pipe) pv = 1'b0;
    chk("rst_dout", 32'(DOUT), 32'h0);
    check_outs();
    RESET_N = 1'b1;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_infl = 0;
    m_err = 0;
    m_stall = 0;
    pv = 0;
    pd = 0;
    nd = 8'h10;
    RESET_N    = 1'b0;
    ISSUE      = 1'b0;
    DIN        = '0;
    DIN_VALID  = 1'b0;
    DOUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset(0);
    repeat (3) tick(0, 1, 1, 0);

    // Back-to-back issue of 0x10..0x17 with the consumer always ready.
    nd = 8'h10;
    repeat (8) tick(1, 1, 1, 0);
    repeat (3) tick(0, 1, 1, 0);

    // Consumer stalled: credits run out at four, then drain in order.
    repeat (8) tick(1, 1, 0, 0);
    chk("peak_count", 32'(COUNT), 32'd4);
    repeat (6) tick(0, 1, 1, 0);

    // Illegal issue at zero credit, then forced push+pop at full.
    do_reset(0);
    repeat (6) tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 1, 1, 1);
    repeat (6) tick(0, 1, 1, 0);

    // Stall statistics: one item held for ten cycles.
    do_reset(0);
    tick(1, 1, 1, 0);
    tick(0, 1, 0, 0);
    repeat (10) tick(0, 1, 0, 0);
    chk("stall10", 32'(STALL_CYCLES), STATS ? 32'd10 : 32'd0);
    repeat (3) tick(0, 1, 1, 0);

    // Reset at COUNT=3 with one item still in the delay line.
    do_reset(0);
    repeat (4) tick(1, 1, 0, 0);
    chk("pre_rst_count", 32'(COUNT), 32'd3);
    do_reset(1);
    tick(0, 1, 1, 0);
    repeat (3) tick(0, 1, 1, 0);

    // Randomized traffic, mostly legal.
    do_reset(0);
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom % 2), ($urandom % 16) != 0, ($urandom % 4) != 0,
           ($urandom % 32) == 0);
    end
    repeat (8) tick(0, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/latency_credit_buffer.md
Name: latency_credit_buffer

Overview:
Output stage directly downstream of the fixed-latency `delay` pipeline primitive. It absorbs data that emerges DELAY cycles after issue and presents it to a backpressuring consumer over valid/ready. Upstream issue is credit-gated, so data already in flight inside the delay line can never overflow the buffer.

Parameters:
DATA_WIDTH, 8, width of DIN/DOUT.
DELAY, 1, fixed upstream latency in cycles from ISSUE to DIN_VALID; informational, checked by elaboration assert (DELAY >= 1).
FIFO_DEPTH, 4, storage entries; power of two, >= 2, and must be >= DELAY+1 for full throughput (elaboration assert FIFO_DEPTH >= 2).
CNT_W, $clog2(FIFO_DEPTH)+1, width of occupancy/credit counters.

Ports:
CLK  in  1  clock, all state on rising edge.
RESET_N  in  1  asynchronous active-low reset.
ISSUE  in  1  upstream pushes one item into the delay line this cycle.
ISSUE_READY  out  1  a credit is available; ISSUE is legal only when high.
DIN  in  DATA_WIDTH  data leaving the delay line.
DIN_VALID  in  1  DIN valid (DELAY cycles after the matching ISSUE).
DOUT  out  DATA_WIDTH  head-of-FIFO data.
DOUT_VALID  out  1  DOUT valid.
DOUT_READY  in  1  consumer accepts DOUT when DOUT_VALID && DOUT_READY.
COUNT  out  CNT_W  current FIFO occupancy.
ERR  out  1  sticky protocol-error flag.
STALL_CYCLES  out  16  stall statistics (see Optional Feature).

Behaviour:
- Reset (RESET_N low, async): wr/rd pointers, COUNT, inflight counter = 0; DOUT_VALID=0, DOUT=0, ERR=0, STALL_CYCLES=0; ISSUE_READY=1 once reset deasserts. Reset mid-operation discards stored and in-flight items; DIN_VALID pulses for discarded items arriving after reset are counted as errors (ERR=1).
- Credits: inflight += ISSUE&&ISSUE_READY; inflight -= DIN_VALID (when inflight>0). Same-cycle ISSUE and DIN_VALID leave inflight unchanged.
- ISSUE_READY = (COUNT + inflight) < FIFO_DEPTH. It is combinational from registered state only; no combinational path from ISSUE or DOUT_READY.
- Write: DIN_VALID stores DIN at wr_ptr; pointers wrap modulo FIFO_DEPTH.
- Read: pop on DOUT_VALID && DOUT_READY.
- DOUT/DOUT_VALID are first-word-fall-through from storage, driven by registered state.
- Latency: DIN_VALID at cycle t into an empty FIFO gives DOUT_VALID=1 at t+1. No same-cycle bypass.
- Push and pop in the same cycle: COUNT unchanged, both pointers advance. This is legal at COUNT=FIFO_DEPTH and at COUNT=1.
- DOUT stays stable while DOUT_VALID && !DOUT_READY.
- Throughput: with DOUT_READY held high and FIFO_DEPTH >= DELAY+1, ISSUE may be high every cycle.
- Errors (set ERR, sticky until reset):
  - ISSUE while ISSUE_READY=0: ignored, not counted.
  - DIN_VALID with inflight=0: data still written if COUNT<FIFO_DEPTH.
  - DIN_VALID when full with no simultaneous pop: data dropped, COUNT unchanged.

Optional Feature:
Macro LATENCY_CREDIT_BUFFER_STATS_EN.
- Defined: STALL_CYCLES is a 16-bit counter incrementing each cycle where DOUT_VALID && !DOUT_READY. It saturates at 16'hFFFF and clears only on reset.
- Undefined: the counter logic is removed and STALL_CYCLES is tied to 0.
- The port is present in both builds.

Test Plan:
- Reset then idle: COUNT=0, DOUT_VALID=0, ISSUE_READY=1, ERR=0; assert RESET_N low mid-stream with COUNT=3 -> all outputs return to reset values the same instant.
- DELAY=1, FIFO_DEPTH=4, issue 8 items (DIN=0x10..0x17) back-to-back with DOUT_READY=1 -> ISSUE_READY stays 1; DOUT sequence 0x10..0x17 in order, one per cycle, each DOUT_VALID one cycle after its DIN_VALID.
- DOUT_READY=0, issue continuously -> ISSUE_READY drops once COUNT+inflight=4; COUNT peaks at 4; no data loss; ERR=0. Releasing DOUT_READY drains 4 items in order.
- Simultaneous push/pop at COUNT=4 and COUNT=1 -> COUNT unchanged; pointer wrap after 5+ items gives correct data order.
- Protocol violations: ISSUE with ISSUE_READY=0 -> ERR=1, inflight unchanged; DIN_VALID with inflight=0 -> ERR=1.
- With LATENCY_CREDIT_BUFFER_STATS_EN: hold DOUT_VALID=1, DOUT_READY=0 for 10 cycles -> STALL_CYCLES=10. Without the macro -> STALL_CYCLES=0.
